pc_trace_checker: RTL and testbench
===================================

// Module: pc_trace_checker
// PURPOSE
//   Parametrised, synthesizable self-checking monitor for PipelinedARMv8 bring-up benches and FPGA runs.
//   Holds an expected program-counter trace and compares it, in order, against PCs the pipeline retires.
//   Flushed slots are skipped, and the result is latched as PASS/FAIL/TIMEOUT with diagnostics.
//   Sits beside the core; taps PC_out, IF_ID_Flush and the IF/ID instruction; drives LEDs or the bench.
// PARAMETERS
//   PC_WIDTH     64   width of compared PC
//   INSTR_WIDTH  32   width of captured instruction word
//   DEPTH        16   expected-trace entries; power of two, >=2
//   TIMEOUT      64   max cycles between accepted matches before TIMEOUT; >=1
//   CW           32   width of cycle/flush counters
// PORTS
//   clock           in   1              single clock, rising edge
//   reset           in   1              synchronous, active-high
//   exp_we          in   1              write expected entry (IDLE only)
//   exp_addr        in   clog2(DEPTH)   expected entry index
//   exp_data        in   PC_WIDTH       expected PC value
//   num_expected    in   clog2(DEPTH)+1 trace length, sampled on start
//   start           in   1              begin check
//   pc_valid        in   1              pc_in/instr_in valid this cycle
//   pc_in           in   PC_WIDTH       retired PC
//   flush_in        in   1              slot squashed; never compared
//   instr_in        in   INSTR_WIDTH    instruction in that slot
//   busy            out  1              state RUN
//   done            out  1              state PASS, FAIL or TIMEOUT
//   pass            out  1              state PASS
//   fail            out  1              state FAIL or TIMEOUT
//   timeout         out  1              state TIMEOUT
//   match_count     out  clog2(DEPTH)+1 entries matched so far
//   bad_pc          out  PC_WIDTH       pc_in at mismatch
//   bad_expected    out  PC_WIDTH       expected PC at mismatch
//   bad_instr       out  INSTR_WIDTH    instr_in at mismatch
//   cycle_count     out  CW             cycles spent in RUN
//   flush_count     out  CW             valid samples skipped due to flush_in
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; counters 0. Expected RAM contents are not cleared. Reset mid-RUN aborts at once.
//   - States: IDLE, RUN, PASS, FAIL, TIMEOUT; one-hot decode drives the status outputs (registered).
//   - IDLE: exp_we writes exp_data to RAM[exp_addr] at the edge. start -> RUN; the same edge latches num_expected and clears
//     idx, match_count, cycle_count, flush_count, the idle timer and bad_*. num_expected==0 with start -> PASS directly.
//     exp_we is ignored outside IDLE. A simultaneous exp_we+start in IDLE performs the write.
//   - RUN: cycle_count += 1 every cycle, saturating at all-ones. Per cycle, priority order:
//       1) pc_valid & flush_in: flush_count++ (saturating); no compare; idle timer keeps counting.
//       2) pc_valid & !flush_in & pc_in==RAM[idx]: match_count++, idx++, idle timer := 0;
//          if match_count+1 == latched num_expected -> PASS (same edge).
//       3) pc_valid & !flush_in & mismatch -> FAIL; capture bad_pc, bad_expected=RAM[idx], bad_instr.
//       4) otherwise, idle timer++; when it reaches TIMEOUT-1 with no match this cycle -> TIMEOUT.
//     Compare is combinational against RAM[idx] (read async or pre-fetched); decision latency is 1 edge after the sample.
//   - RUN, start: ignored.
//   - PASS/FAIL/TIMEOUT: hold all outputs. pc_valid is ignored. start restarts exactly as from IDLE (same trace).
//   - Samples after the final match are not checked (state is PASS). idx never exceeds DEPTH-1.
//   - num_expected > DEPTH is clamped to DEPTH when latched.
// TESTING
//   - RAM={0,24,28,36}, n=4; feed PCs 0,24,28,36, no flush -> pass=1 one edge after 36, match_count=4, fail=0.
//   - Same trace; feed 0,4(flush),8(flush),24,28,36 -> pass=1, flush_count=2, match_count=4.
//   - Same trace; feed 0,24,32 -> fail=1, timeout=0, bad_pc=32, bad_expected=28, match_count=2.
//   - TIMEOUT=8, n=4; feed 0, then pc_valid=0 -> timeout=fail=1 exactly 8 cycles after last match, match_count=1.
//   - n=0 with start -> pass=1 next edge, cycle_count=0; then assert reset during a RUN of n=4 -> all outputs 0 next edge.
//   - After FAIL, pulse start and replay the correct trace -> pass=1, counters restarted from 0; exp_we in RUN leaves RAM unchanged.

Source files
------------

// File: rtl/pc_trace_checker.sv
// pc_trace_checker: compares retired PCs in order against a stored expected trace,
// skipping flushed slots, and latches PASS/FAIL/TIMEOUT with mismatch diagnostics.
module pc_trace_checker #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT     = 64,
    parameter int CW          = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_addr,
    input  logic [PC_WIDTH-1:0]      exp_data,
    input  logic [$clog2(DEPTH):0]   num_expected,
    input  logic                     start,
    input  logic                     pc_valid,
    input  logic [PC_WIDTH-1:0]      pc_in,
    input  logic                     flush_in,
    input  logic [INSTR_WIDTH-1:0]   instr_in,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   match_count,
    output logic [PC_WIDTH-1:0]      bad_pc,
    output logic [PC_WIDTH-1:0]      bad_expected,
    output logic [INSTR_WIDTH-1:0]   bad_instr,
    output logic [CW-1:0]            cycle_count,
    output logic [CW-1:0]            flush_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] NMAX = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_RUN  = 5'b00010,
        S_PASS = 5'b00100,
        S_FAIL = 5'b01000,
        S_TMO  = 5'b10000
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    mem_q [DEPTH];
    logic [AW-1:0]          idx_q, idx_d;
    logic [AW:0]            num_q, num_d, match_q, match_d, num_lat;
    logic [TW-1:0]          timer_q, timer_d;
    logic [CW-1:0]          cycle_q, cycle_d, flush_q, flush_d;
    logic [PC_WIDTH-1:0]    bad_pc_q, bad_pc_d, bad_exp_q, bad_exp_d, exp_pc;
    logic [INSTR_WIDTH-1:0] bad_instr_q, bad_instr_d;
    logic                   run, launch, sample, hit, miss, last, expire;

    always_comb begin
        exp_pc  = mem_q[idx_q];
        run     = state_q == S_RUN;
        launch  = start & ~run;
        sample  = pc_valid & ~flush_in;
        hit     = run & sample & (pc_in == exp_pc);
        miss    = run & sample & (pc_in != exp_pc);
        last    = match_q + 1'b1 == num_q;
        expire  = run & ~sample & (timer_q == TLAST);
        num_lat = (num_expected > NMAX) ? NMAX : num_expected;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (launch) state_d = (num_lat == '0) ? S_PASS : S_RUN;
        else if (hit & last) state_d = S_PASS;
        else if (miss) state_d = S_FAIL;
        else if (expire) state_d = S_TMO;
    end

    always_comb begin
        busy    = state_q == S_RUN;
        done    = (state_q == S_PASS) | (state_q == S_FAIL) | (state_q == S_TMO);
        pass    = state_q == S_PASS;
        fail    = (state_q == S_FAIL) | (state_q == S_TMO);
        timeout = state_q == S_TMO;
    end

    always_comb begin
        idx_d       = idx_q;
        num_d       = num_q;
        match_d     = match_q;
        timer_d     = timer_q;
        cycle_d     = cycle_q;
        flush_d     = flush_q;
        bad_pc_d    = bad_pc_q;
        bad_exp_d   = bad_exp_q;
        bad_instr_d = bad_instr_q;
        if (launch) begin
            num_d       = num_lat;
            idx_d       = '0;
            match_d     = '0;
            timer_d     = '0;
            cycle_d     = '0;
            flush_d     = '0;
            bad_pc_d    = '0;
            bad_exp_d   = '0;
            bad_instr_d = '0;
        end else if (run) begin
            cycle_d = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
            flush_d = (pc_valid & flush_in & ~&flush_q) ? flush_q + 1'b1 : flush_q;
            timer_d = hit ? '0 : timer_q + 1'b1;
            match_d = hit ? match_q + 1'b1 : match_q;
            idx_d   = hit ? idx_q + 1'b1 : idx_q;
            if (miss) begin
                bad_pc_d    = pc_in;
                bad_exp_d   = exp_pc;
                bad_instr_d = instr_in;
            end
        end
    end

    // Trace RAM survives reset so a bench can reload once and rerun
    always_ff @(posedge clock) begin
        if (exp_we && state_q == S_IDLE) mem_q[exp_addr] <= exp_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q       <= '0;
            num_q       <= '0;
            match_q     <= '0;
            timer_q     <= '0;
            cycle_q     <= '0;
            flush_q     <= '0;
            bad_pc_q    <= '0;
            bad_exp_q   <= '0;
            bad_instr_q <= '0;
        end else begin
            idx_q       <= idx_d;
            num_q       <= num_d;
            match_q     <= match_d;
            timer_q     <= timer_d;
            cycle_q     <= cycle_d;
            flush_q     <= flush_d;
            bad_pc_q    <= bad_pc_d;
            bad_exp_q   <= bad_exp_d;
            bad_instr_q <= bad_instr_d;
        end
    end

    assign match_count  = match_q;
    assign bad_pc       = bad_pc_q;
    assign bad_expected = bad_exp_q;
    assign bad_instr    = bad_instr_q;
    assign cycle_count  = cycle_q;
    assign flush_count  = flush_q;
endmodule

// File: tb/tb_pc_trace_checker.sv
// tb_pc_trace_checker: directed and random runs of pc_trace_checker; a trace-walking
// reference model predicts each run's verdict and a monitor checks it when done rises.
module tb_pc_trace_checker;
    localparam int DEPTH = 16;
    localparam int TMO   = 8;

    logic        clock = 0, reset = 1;
    logic        exp_we = 0, start = 0, pc_valid = 0, flush_in = 0;
    logic [3:0]  exp_addr = 0;
    logic [63:0] exp_data = 0, pc_in = 0;
    logic [4:0]  num_expected = 0;
    logic [31:0] instr_in = 0;
    logic        busy, done, pass, fail, timeout;
    logic [4:0]  match_count;
    logic [63:0] bad_pc, bad_expected;
    logic [31:0] bad_instr, cycle_count, flush_count;

    pc_trace_checker #(.PC_WIDTH(64), .INSTR_WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(TMO), .CW(32)) dut (
        .clock(clock), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .num_expected(num_expected), .start(start), .pc_valid(pc_valid), .pc_in(pc_in),
        .flush_in(flush_in), .instr_in(instr_in), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .match_count(match_count), .bad_pc(bad_pc),
        .bad_expected(bad_expected), .bad_instr(bad_instr), .cycle_count(cycle_count),
        .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic v, f, we;
        logic [3:0] wa;
        logic [63:0] wd, pc;
        logic [31:0] ins;
    } stim_t;

    typedef struct packed {
        logic ps, fl, to;
        logic [4:0] mc;
        logic [31:0] fc, cc;
        logic [63:0] bp, be;
        logic [31:0] bi;
    } exp_t;

    stim_t       stim_q[$];
    exp_t        exp_q[$];
    exp_t        last_e;
    logic [63:0] exp_mem [DEPTH];
    int          tests = 0, errors = 0;

    // Walk the trace: a flush or empty cycle counts toward the gap since the last match
    function automatic exp_t model(int n);
        exp_t e;
        int nn, m, idle;
        e = '0;
        nn = n > DEPTH ? DEPTH : n;
        m = 0;
        idle = 0;
        if (nn == 0) begin
            e.ps = 1;
            return e;
        end
        for (int c = 0; c < 10000; c++) begin
            stim_t s;
            s = '0;
            if (c < stim_q.size()) s = stim_q[c];
            e.cc++;
            if (s.v && !s.f) begin
                if (s.pc == exp_mem[m]) begin
                    m++;
                    idle = 0;
                    e.mc = 5'(m);
                    if (m == nn) begin
                        e.ps = 1;
                        return e;
                    end
                end else begin
                    e.fl = 1;
                    e.bp = s.pc;
                    e.be = exp_mem[m];
                    e.bi = s.ins;
                    return e;
                end
            end else begin
                if (s.v) e.fc++;
                idle++;
                if (idle == TMO) begin
                    e.fl = 1;
                    e.to = 1;
                    return e;
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic check_res(input string tag, input exp_t e);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_pass"}, 64'(pass), 64'(e.ps));
        chk({tag, "_fail"}, 64'(fail), 64'(e.fl));
        chk({tag, "_timeout"}, 64'(timeout), 64'(e.to));
        chk({tag, "_match_count"}, 64'(match_count), 64'(e.mc));
        chk({tag, "_flush_count"}, 64'(flush_count), 64'(e.fc));
        chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(e.cc));
        chk({tag, "_bad_pc"}, bad_pc, e.bp);
        chk({tag, "_bad_expected"}, bad_expected, e.be);
        chk({tag, "_bad_instr"}, 64'(bad_instr), 64'(e.bi));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_pass"}, 64'(pass), 0);
        chk({tag, "_fail"}, 64'(fail), 0);
        chk({tag, "_timeout"}, 64'(timeout), 0);
        chk({tag, "_match_count"}, 64'(match_count), 0);
        chk({tag, "_cycle_count"}, 64'(cycle_count), 0);
        chk({tag, "_flush_count"}, 64'(flush_count), 0);
        chk({tag, "_bad_pc"}, bad_pc, 0);
        chk({tag, "_bad_expected"}, bad_expected, 0);
        chk({tag, "_bad_instr"}, 64'(bad_instr), 0);
    endtask

    // Monitor: each rising done retires the oldest predicted verdict
    initial begin
        logic pd;
        pd = 0;
        forever begin
            @(negedge clock);
            if (done && !pd) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    last_e = exp_q.pop_front();
                    check_res("result", last_e);
                end
            end
            pd = done;
        end
    end

    task automatic idle_in();
        pc_valid = 0;
        flush_in = 0;
        exp_we = 0;
        pc_in = 0;
        instr_in = 0;
    endtask

    task automatic drive(input stim_t s);
        pc_valid = s.v;
        flush_in = s.f;
        pc_in = s.pc;
        instr_in = s.ins;
        exp_we = s.we;
        exp_addr = s.wa;
        exp_data = s.wd;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_in();
        @(negedge clock);
        reset = 0;
    endtask

    task automatic load(input int a, input logic [63:0] d);
        exp_we = 1;
        exp_addr = 4'(a);
        exp_data = d;
        exp_mem[a] = d;
        @(negedge clock);
        exp_we = 0;
    endtask

    task automatic add(input bit v, input bit f, input logic [63:0] pc);
        stim_t s;
        s = '0;
        s.v = v;
        s.f = f;
        s.pc = pc;
        s.ins = 32'hE000_0000 | pc[31:0];
        stim_q.push_back(s);
    endtask

    task automatic run(input int n, input bit wr, input int wa, input logic [63:0] wd);
        int k;
        if (wr) begin
            exp_we = 1;
            exp_addr = 4'(wa);
            exp_data = wd;
            exp_mem[wa] = wd;
        end
        start = 1;
        num_expected = 5'(n);
        exp_q.push_back(model(n));
        @(negedge clock);
        start = 0;
        exp_we = 0;
        foreach (stim_q[i]) begin
            drive(stim_q[i]);
            @(negedge clock);
        end
        idle_in();
        k = 0;
        while (!done && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (!done) begin
            tests++;
            errors++;
            $display("FAIL wait_done: got done=0 expected done within 200 cycles");
            exp_q.delete();
        end
        repeat (3) begin
            pc_valid = 1;
            pc_in = {$urandom, $urandom};
            @(negedge clock);
        end
        idle_in();
        chk("hold_pass", 64'(pass), 64'(last_e.ps));
        chk("hold_fail", 64'(fail), 64'(last_e.fl));
        chk("hold_match_count", 64'(match_count), 64'(last_e.mc));
        chk("hold_cycle_count", 64'(cycle_count), 64'(last_e.cc));
        chk("hold_bad_pc", bad_pc, last_e.bp);
    endtask

    initial begin
        stim_t s;
        int n, nn, gap;
        @(negedge clock);
        do_reset();
        check_zero("reset");

        load(0, 0); load(1, 24); load(2, 28);
        stim_q.delete(); add(1, 0, 0); add(1, 0, 24); add(1, 0, 28); add(1, 0, 36);
        run(4, 1, 3, 36);

        do_reset();
        stim_q.delete(); add(1, 0, 0); add(1, 1, 4); add(1, 1, 8); add(1, 0, 24); add(1, 0, 28); add(1, 0, 36);
        run(4, 0, 0, 0);

        do_reset();
        stim_q.delete(); add(1, 0, 0); add(1, 0, 24); add(1, 0, 32);
        run(4, 0, 0, 0);

        // Restart straight from FAIL; the in-run write to entry 3 must be dropped
        stim_q.delete(); add(1, 0, 0); add(1, 0, 24); add(1, 0, 28); add(1, 0, 36);
        stim_q[1].we = 1; stim_q[1].wa = 3; stim_q[1].wd = 99;
        run(4, 0, 0, 0);

        do_reset();
        stim_q.delete(); add(1, 0, 0);
        run(4, 0, 0, 0);

        do_reset();
        stim_q.delete();
        run(0, 0, 0, 0);

        do_reset();
        start = 1; num_expected = 4;
        @(negedge clock);
        start = 0; pc_valid = 1; pc_in = 0;
        @(negedge clock);
        pc_in = 24;
        @(negedge clock);
        chk("mid_busy", 64'(busy), 1);
        chk("mid_match_count", 64'(match_count), 2);
        do_reset();
        check_zero("abort");

        repeat (25) begin
            do_reset();
            n = $urandom_range(0, 20);
            nn = n > DEPTH ? DEPTH : n;
            for (int k = 0; k < DEPTH; k++)
                if (k < nn || $urandom_range(0, 1) == 1) load(k, {$urandom, $urandom} & ~64'h3);
            stim_q.delete();
            for (int k = 0; k < nn; k++) begin
                gap = ($urandom_range(0, 19) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
                repeat (gap) begin
                    s = '0;
                    s.pc = {$urandom, $urandom};
                    s.ins = $urandom;
                    case ($urandom_range(0, 2))
                        0: begin s.v = 1; s.f = 1; end
                        1: s.f = 1'($urandom_range(0, 1));
                        default: s.v = 0;
                    endcase
                    s.we = $urandom_range(0, 9) == 0;
                    s.wa = 4'($urandom);
                    s.wd = {$urandom, $urandom};
                    stim_q.push_back(s);
                end
                s = '0;
                s.v = 1;
                s.ins = $urandom;
                s.pc = ($urandom_range(0, 11) == 0) ? exp_mem[k] ^ 64'h4 : exp_mem[k];
                stim_q.push_back(s);
            end
            add(1, 0, {$urandom, $urandom});
            run(n, 1'($urandom_range(0, 3) == 0), $urandom_range(0, DEPTH - 1), {$urandom, $urandom} & ~64'h3);
        end

        if (exp_q.size() != 0) begin
            tests++;
            errors++;
            $display("FAIL leftover_results: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
